// File: rtl/shift_rotate_pkg.sv
// Shared definitions for the pipelined shift/rotate unit: op encoding, stage modes
// and the carry-out helper used by the output stage.
package shift_rotate_pkg;

    localparam logic [2:0] OP_ROL = 3'b000;
    localparam logic [2:0] OP_ROR = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;

    // Widest operand the carry helper handles; the top level zero-extends into it.
    localparam int unsigned MAX_W = 64;
    localparam int unsigned IDX_W = 6;

    typedef logic [MAX_W-1:0] wide_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [2:0] {
        ModePass,
        ModeRol,
        ModeRor,
        ModeShl,
        ModeShr
    } stage_mode_e;

    function automatic logic is_reserved(input logic [2:0] op);
        return op > OP_SRA;
    endfunction

    function automatic stage_mode_e op_to_mode(input logic [2:0] op);
        stage_mode_e mode;
        mode = ModePass;
        case (op)
            OP_ROL:         mode = ModeRol;
            OP_ROR:         mode = ModeRor;
            OP_SLL:         mode = ModeShl;
            OP_SRL, OP_SRA: mode = ModeShr;
            default:        mode = ModePass;
        endcase
        return mode;
    endfunction

    // src is the original operand, res the final result, msb = width-1 and k the amount
    // modulo width; amt_eq_w marks an amount exactly equal to the width.
    function automatic logic calc_carry(
        input logic [2:0] op,
        input wide_t      src,
        input wide_t      res,
        input idx_t       msb,
        input idx_t       k,
        input logic       amt_zero,
        input logic       sat,
        input logic       amt_eq_w
    );
        logic c;
        c = 1'b0;
        case (op)
            OP_ROL: c = (k != '0) ? res[0] : 1'b0;
            OP_ROR: c = (k != '0) ? res[msb] : 1'b0;
            OP_SLL: begin
                if (amt_eq_w) begin
                    c = src[0];
                end else if (!sat && !amt_zero) begin
                    c = src[msb - (k - idx_t'(1))];
                end
            end
            OP_SRL: begin
                if (amt_eq_w) begin
                    c = src[msb];
                end else if (!sat && !amt_zero) begin
                    c = src[k - idx_t'(1)];
                end
            end
            OP_SRA: begin
                if (sat) begin
                    c = src[msb];
                end else if (!amt_zero) begin
                    c = src[k - idx_t'(1)];
                end
            end
            default: c = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/shift_rotate_stage.sv
// Combinational shift/rotate by one bit-group of the shift amount. Right shifts
// take their vacated bits from the fill input, so one path serves SRL and SRA.
module shift_rotate_stage
    import shift_rotate_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned GRP_W   = 2,
    parameter int unsigned GRP_LSB = 0
) (
    input  logic [WIDTH-1:0] data,
    input  logic [GRP_W-1:0] amt,
    input  stage_mode_e      mode,
    input  logic             fill,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    logic [SHAMT_W-1:0] shamt;
    int unsigned        sh;
    int unsigned        rsh;

    always_comb begin
        shamt = SHAMT_W'(amt) << GRP_LSB;
        sh    = 32'(shamt);
        // A shift by WIDTH yields zero, which makes the sh == 0 cases fall out naturally.
        rsh   = WIDTH - sh;
        result = data;
        case (mode)
            ModeRol: result = (data << sh) | (data >> rsh);
            ModeRor: result = (data >> sh) | (data << rsh);
            ModeShl: result = data << sh;
            ModeShr: result = (data >> sh) | ({WIDTH{fill}} << rsh);
            default: result = data;
        endcase
    end

endmodule

// File: rtl/shift_rotate_pipe.sv
// Two-stage shift/rotate unit with valid/ready on both sides: S1 holds the
// coarse-shifted operand, S2 the fine-shifted result and its flags.
module shift_rotate_pipe
    import shift_rotate_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [WIDTH-1:0] in_amt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_err
);

    localparam int unsigned SHAMT_W  = $clog2(WIDTH);
    localparam int unsigned FINE_W   = SHAMT_W / 2;
    localparam int unsigned COARSE_W = SHAMT_W - FINE_W;

    logic s2_load;
    logic in_xfer;

    logic             in_fill;
    logic             in_sat;
    logic             in_amt_zero;
    logic             in_amt_eq_w;
    stage_mode_e      in_mode;
    logic [WIDTH-1:0] coarse_data;

    logic               s1_valid_q;
    logic [WIDTH-1:0]   s1_data_q;
    logic [WIDTH-1:0]   s1_src_q;
    logic [2:0]         s1_op_q;
    logic [SHAMT_W-1:0] s1_k_q;
    logic               s1_sat_q;
    logic               s1_amt_zero_q;
    logic               s1_amt_eq_w_q;

    logic             s1_fill;
    stage_mode_e      s1_mode;
    logic [WIDTH-1:0] fine_data;

    logic [WIDTH-1:0] res_d;
    logic             carry_d;
    logic             zero_d;
    logic             err_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_carry_q;
    logic             out_zero_q;
    logic             out_err_q;

    // Handshake: no skid buffer, so in_ready looks straight through to the output side.
    assign s2_load  = !out_valid_q || out_ready;
    assign in_ready = !flush && (!s1_valid_q || s2_load);
    assign in_xfer  = in_valid && in_ready;

    assign in_mode     = op_to_mode(in_op);
    assign in_fill     = (in_op == OP_SRA) && in_data[WIDTH-1];
    assign in_sat      = |in_amt[WIDTH-1:SHAMT_W];
    assign in_amt_zero = (in_amt == '0);
    assign in_amt_eq_w = (in_amt == WIDTH'(WIDTH));

    shift_rotate_stage #(
        .WIDTH   (WIDTH),
        .GRP_W   (COARSE_W),
        .GRP_LSB (FINE_W)
    ) u_coarse (
        .data   (in_data),
        .amt    (in_amt[SHAMT_W-1:FINE_W]),
        .mode   (in_mode),
        .fill   (in_fill),
        .result (coarse_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_data_q     <= '0;
            s1_src_q      <= '0;
            s1_op_q       <= '0;
            s1_k_q        <= '0;
            s1_sat_q      <= 1'b0;
            s1_amt_zero_q <= 1'b0;
            s1_amt_eq_w_q <= 1'b0;
        end else begin
            if (flush) begin
                s1_valid_q <= 1'b0;
            end else if (in_ready) begin
                s1_valid_q <= in_valid;
            end
            if (in_xfer) begin
                s1_data_q     <= coarse_data;
                s1_src_q      <= in_data;
                s1_op_q       <= in_op;
                s1_k_q        <= in_amt[SHAMT_W-1:0];
                s1_sat_q      <= in_sat;
                s1_amt_zero_q <= in_amt_zero;
                s1_amt_eq_w_q <= in_amt_eq_w;
            end
        end
    end

    assign s1_mode = op_to_mode(s1_op_q);
    assign s1_fill = (s1_op_q == OP_SRA) && s1_src_q[WIDTH-1];

    shift_rotate_stage #(
        .WIDTH   (WIDTH),
        .GRP_W   (FINE_W),
        .GRP_LSB (0)
    ) u_fine (
        .data   (s1_data_q),
        .amt    (s1_k_q[FINE_W-1:0]),
        .mode   (s1_mode),
        .fill   (s1_fill),
        .result (fine_data)
    );

    always_comb begin
        res_d = fine_data;
        // Amounts of WIDTH or more: shifts saturate, rotates only see the low bits.
        if (s1_sat_q) begin
            case (s1_op_q)
                OP_SLL, OP_SRL: res_d = '0;
                OP_SRA:         res_d = {WIDTH{s1_src_q[WIDTH-1]}};
                default:        res_d = fine_data;
            endcase
        end
        carry_d = calc_carry(s1_op_q, MAX_W'(s1_src_q), MAX_W'(res_d), idx_t'(WIDTH - 1),
                             idx_t'(s1_k_q), s1_amt_zero_q, s1_sat_q, s1_amt_eq_w_q);
        zero_d  = (res_d == '0);
        err_d   = is_reserved(s1_op_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_carry_q <= 1'b0;
            out_zero_q  <= 1'b0;
            out_err_q   <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (s2_load) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_data_q  <= res_d;
                out_carry_q <= carry_d;
                out_zero_q  <= zero_d;
                out_err_q   <= err_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_carry = out_carry_q;
    assign out_zero  = out_zero_q;
    assign out_err   = out_err_q;

endmodule

// File: tb/tb_shift_rotate_pipe.sv
// Scoreboard bench for shift_rotate_pipe: the driver queues hand-computed results
// on each input transfer, the monitor pops and compares on each output transfer.
module tb_shift_rotate_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic [15:0] in_amt;
    logic [2:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_carry;
    logic        out_zero;
    logic        out_err;

    always #5 clk = ~clk;

    shift_rotate_pipe #(
        .WIDTH (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_zero  (out_zero),
        .out_err   (out_err)
    );

    typedef struct {
        logic [2:0]  op;
        logic [15:0] data;
        logic [15:0] amt;
        logic [15:0] res;
        logic        carry;
        logic        zero;
        logic        err;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic        carry;
        logic        zero;
        logic        err;
    } exp_t;

    vec_t vecs[20];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pops   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] op, input logic [15:0] data,
                                input logic [15:0] amt, input logic [15:0] res,
                                input logic carry, input logic zero, input logic err);
        vec_t v;
        v.op = op; v.data = data; v.amt = amt;
        v.res = res; v.carry = carry; v.zero = zero; v.err = err;
        return v;
    endfunction

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.res = v.res; e.carry = v.carry; e.zero = v.zero; e.err = v.err;
        exp_q.push_back(e);
    endtask

    task automatic drive(input vec_t v);
        in_op   = v.op;
        in_data = v.data;
        in_amt  = v.amt;
    endtask

    // Present a beat until accepted; transfer is judged at the negedge before the edge.
    task automatic send(input vec_t v);
        int t;
        bit done;
        t = 0;
        done = 0;
        drive(v);
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                push_exp(v);
                done = 1;
            end else begin
                t++;
                if (t > 50) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL send_timeout: in_ready stayed 0, required 1");
                    done = 1;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // Beat presented in cycle 0 on an empty pipe must show out_valid in cycle 2.
    task automatic send_timed(input vec_t v);
        drive(v);
        in_valid = 1'b1;
        @(negedge clk);
        check("lat_accept", in_ready, 1);
        if (in_ready) push_exp(v);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("lat_cycle1_valid", out_valid, 0);
        @(negedge clk);
        check("lat_cycle2_valid", out_valid, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        #1;
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Monitor: compare on every output transfer, and check stalled outputs stay put.
    exp_t        mon_e;
    logic        hold_valid = 1'b0;
    logic [15:0] hold_data;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_valid = 1'b0;
            end else begin
                if (hold_valid) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, hold_data);
                end
                hold_valid = 1'b0;
                if (out_valid) begin
                    if (out_ready) begin
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_beat: got data 0x%0h, required no beat",
                                     out_data);
                        end else begin
                            mon_e = exp_q.pop_front();
                            n_pops++;
                            check("out_data", out_data, mon_e.res);
                            check("out_carry", out_carry, mon_e.carry);
                            check("out_zero", out_zero, mon_e.zero);
                            check("out_err", out_err, mon_e.err);
                        end
                    end else if (!flush) begin
                        hold_valid = 1'b1;
                        hold_data  = out_data;
                    end
                end
            end
        end
    end

    initial begin
        int pops_before;

        vecs[0]  = mk(3'b000, 16'h800B, 16'd4,     16'h00B8, 0, 0, 0);
        vecs[1]  = mk(3'b001, 16'h000B, 16'd4,     16'hB000, 1, 0, 0);
        vecs[2]  = mk(3'b000, 16'h1234, 16'd20,    16'h2341, 1, 0, 0);
        vecs[3]  = mk(3'b100, 16'h8000, 16'd20,    16'hFFFF, 1, 0, 0);
        vecs[4]  = mk(3'b010, 16'h0001, 16'd16,    16'h0000, 1, 1, 0);
        vecs[5]  = mk(3'b011, 16'hFFFF, 16'd17,    16'h0000, 0, 1, 0);
        vecs[6]  = mk(3'b110, 16'h5A5A, 16'd3,     16'h5A5A, 0, 0, 1);
        vecs[7]  = mk(3'b100, 16'h8F00, 16'd4,     16'hF8F0, 0, 0, 0);
        vecs[8]  = mk(3'b011, 16'h00F1, 16'd1,     16'h0078, 1, 0, 0);
        vecs[9]  = mk(3'b010, 16'h8001, 16'd1,     16'h0002, 1, 0, 0);
        vecs[10] = mk(3'b000, 16'hABCD, 16'd0,     16'hABCD, 0, 0, 0);
        vecs[11] = mk(3'b011, 16'h8000, 16'd16,    16'h0000, 1, 1, 0);
        vecs[12] = mk(3'b001, 16'h0001, 16'd1,     16'h8000, 1, 0, 0);
        vecs[13] = mk(3'b100, 16'h7FFF, 16'd15,    16'h0000, 1, 1, 0);
        vecs[14] = mk(3'b010, 16'h1234, 16'd0,     16'h1234, 0, 0, 0);
        vecs[15] = mk(3'b100, 16'h4000, 16'hFFFF,  16'h0000, 0, 1, 0);
        vecs[16] = mk(3'b001, 16'h1234, 16'd16,    16'h1234, 0, 0, 0);
        vecs[17] = mk(3'b111, 16'h0000, 16'd5,     16'h0000, 0, 1, 1);
        vecs[18] = mk(3'b010, 16'h00F0, 16'd6,     16'h3C00, 0, 0, 0);
        vecs[19] = mk(3'b000, 16'h8421, 16'd13,    16'h3084, 0, 0, 0);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_amt = '0; in_op = '0;

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_flags", {out_carry, out_zero, out_err}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Latency on an empty pipe, then back-to-back directed vectors
        out_ready = 1'b1;
        send_timed(vecs[0]);
        for (int i = 1; i < 20; i++) send(vecs[i]);
        drain();

        // Backpressure: two beats fill the pipe, the third waits
        out_ready = 1'b0;
        send(vecs[7]);
        send(vecs[8]);
        drive(vecs[9]);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready_low", in_ready, 0);
            check("bp_first_held", out_data, vecs[7].res);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        pops_before = n_pops;
        send(vecs[9]);
        send(vecs[10]);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("bp_one_per_cycle", n_pops - pops_before, 4);
        drain();

        // Flush with two beats in flight and a beat offered in the same cycle
        out_ready = 1'b0;
        send(vecs[11]);
        send(vecs[12]);
        flush = 1'b1;
        drive(vecs[14]);
        in_valid = 1'b1;
        @(negedge clk);
        check("flush_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("flush_out_valid", out_valid, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send_timed(vecs[14]);
        drain();

        // Asynchronous reset with the pipe full
        out_ready = 1'b0;
        send(vecs[13]);
        send(vecs[4]);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_out_carry", out_carry, 0);
        check("arst_out_zero", out_zero, 0);
        check("arst_out_err", out_err, 0);
        exp_q.delete();
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(negedge clk);
        check("arst_in_ready", in_ready, 1);
        check("arst_no_stale", out_valid, 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(vecs[2]);
        drain();
        repeat (4) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_rotate_pipe.md
Name: shift_rotate_pipe

Overview:
Parametrised two-stage pipelined shift/rotate unit for the ALU shifter group. It supersedes the single-mode 16-bit rotate-left register. It supports rotate left/right, logical left/right and arithmetic right shift, and produces carry and zero flags. Valid/ready handshakes on both sides let it sit between the ALU operand mux and the result writeback with backpressure.

Parameters:
WIDTH, 16, data width in bits; must be a power of two, >= 4.
SHAMT_W, $clog2(WIDTH), derived local parameter; not overridable.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous reset, active-high
flush  in  1  synchronous pipeline clear
in_valid  in  1  operand beat valid
in_ready  out  1  unit can accept a beat this cycle
in_data  in  WIDTH  operand
in_amt  in  WIDTH  shift amount; the full width is significant
in_op  in  3  000 ROL, 001 ROR, 010 SLL, 011 SRL, 100 SRA, 101-111 reserved
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts the result
out_data  out  WIDTH  result
out_carry  out  1  last bit shifted or rotated out
out_zero  out  1  out_data == 0
out_err  out  1  reserved op was issued

Behaviour:
- Reset (async, rst=1): both stage valids = 0; out_data, out_carry, out_zero, out_err = 0. in_ready = 1 after reset release.
- Handshake: a beat transfers when valid && ready on the same edge. in_data, in_amt and in_op are sampled only on transfer. Outputs stay stable while out_valid && !out_ready.
- Pipeline: S1 registers the operand, op, the saturation flag (in_amt >= WIDTH) and a coarse shift by in_amt[SHAMT_W-1:SHAMT_W/2]. S2 applies the fine shift by the low bits and registers data and flags into the output register.
- Latency: 2 cycles from transfer edge to out_valid when unstalled. Throughput: 1 beat per cycle.
- Advance rules:
  - S2 loads when S2 is empty or (out_valid && out_ready).
  - S1 advances when S2 loads.
  - in_ready = !flush && (!S1_valid || S2 loads); this is combinational, with no skid buffer.
- Stalled pipeline: at most 2 beats are held. No beat is lost or reordered.
- Rotates (ROL/ROR): effective amount k = in_amt mod WIDTH.
  - k = 0: out_data = in_data, carry = 0.
  - Otherwise: ROL carry = out_data[0]; ROR carry = out_data[WIDTH-1].
- SLL, amount n:
  - n = 0: passthrough, carry = 0.
  - 1..WIDTH: carry = in_data[WIDTH-n].
  - n > WIDTH: data = 0, carry = 0.
- SRL, amount n:
  - n = 0: passthrough, carry = 0.
  - 1..WIDTH: carry = in_data[n-1].
  - n > WIDTH: data = 0, carry = 0.
- SRA, amount n:
  - n = 0: passthrough, carry = 0.
  - 1..WIDTH-1: sign-filled result, carry = in_data[n-1].
  - n >= WIDTH: data = all copies of in_data[WIDTH-1], carry = in_data[WIDTH-1].
- Reserved op: out_data = in_data, carry = 0, out_err = 1 for that beat only. The beat still flows.
- out_zero is computed from the final out_data in S2 and registered alongside it.
- flush: on the edge where flush = 1, both stage valids clear and out_valid drops next cycle. Data registers may hold stale values. No transfer occurs that cycle, because in_ready = 0. flush takes priority over out_ready.
- Reset asserted mid-operation: everything is discarded immediately (async). No output beat is produced for in-flight data.

Decomposition:
- Package shift_rotate_pkg holds the op encoding constants (OP_ROL, OP_ROR, OP_SLL, OP_SRL, OP_SRA) and a function computing the carry bit from op, operand and amount.
- Sub-module shift_rotate_stage: combinational shift/rotate by a given bit-group of the amount, with fill-bit input. It is instantiated once per pipeline stage, coarse and fine.
- The top level holds the handshake/valid logic and the stage registers.

Test Plan:
- ROL 0x800B, amt 4, out_ready=1 -> out_data 0x00B8, carry 0, zero 0, out_valid exactly 2 cycles after transfer.
- ROR 0x000B amt 4 -> 0xB000, carry 1. ROL 0x1234 amt 20 (mod 16 = 4) -> 0x2341, carry 1.
- SRA 0x8000 amt 20 -> 0xFFFF, carry 1. SLL 0x0001 amt 16 -> 0x0000, carry 1, zero 1. SRL 0xFFFF amt 17 -> 0x0000, carry 0, zero 1. Op 110 on 0x5A5A -> 0x5A5A, err 1.
- Backpressure: issue 4 back-to-back beats with out_ready=0 for 5 cycles.
  - Expect: in_ready low after 2 beats accepted.
  - Expect: out_data holds the first result steady.
  - Expect: after out_ready=1, all 4 results exit in order, one per cycle, none duplicated.
- Flush with 2 beats in flight and in_valid=1 in the same cycle -> that beat is not accepted, out_valid=0 the next cycle, and the next accepted beat emerges normally after 2 cycles.
- Assert rst asynchronously between clock edges with the pipeline full -> out_valid and all flags 0 immediately. in_ready=1 on the first edge after release, and no stale beats ever appear.
